// File: rtl/add_share_arbiter_pkg.sv
// Shared types and constants for the shared-adder arbiter.
package add_share_arbiter_pkg;

    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned OPW      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/add_share_arbiter_if.sv
// Requester/result bus for add_share_arbiter.
interface add_share_arbiter_if
    import add_share_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IDW  = 2
);

    logic [NREQ-1:0]     REQ;
    logic [OPW*NREQ-1:0] A_BUS;
    logic [OPW*NREQ-1:0] B_BUS;
    logic [NREQ-1:0]     GNT;
    logic [OPW-1:0]      OUT;
    logic                CARRY;
    logic [IDW-1:0]      OUT_ID;
    logic                OUT_VALID;
    logic                OUT_READY;
    logic                BUSY;

    modport master (
        output REQ, A_BUS, B_BUS, OUT_READY,
        input  GNT, OUT, CARRY, OUT_ID, OUT_VALID, BUSY
    );

    modport slave (
        input  REQ, A_BUS, B_BUS, OUT_READY,
        output GNT, OUT, CARRY, OUT_ID, OUT_VALID, BUSY
    );

endinterface

// File: rtl/ADD.sv
// 8-bit combinational adder with carry-out.
module ADD (
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] S,
    output logic       CO
);

    assign {CO, S} = {1'b0, A} + {1'b0, B};

endmodule

// File: rtl/add_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module add_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] win_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    logic [IDW-1:0] cand;

    // Scan from farthest to nearest so the requester closest to ptr_i is written last.
    always_comb begin
        win_o = '0;
        idx_o = '0;
        any_o = |req_i;
        cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IDW'((32'(ptr_i) + NREQ - 1 - k) % NREQ);
            if (req_i[cand]) begin
                win_o       = '0;
                win_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/add_share_arbiter.sv
// Round-robin arbiter sharing one 8-bit ADD between NREQ requesters,
// with a registered result held under a valid/ready handshake.
module add_share_arbiter
    import add_share_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IDW  = 2
) (
    input  logic              CLK,
    input  logic              RESET,
    add_share_arbiter_if.slave bus
);

    state_e          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [OPW-1:0]  opa_q, opa_d;
    logic [OPW-1:0]  opb_q, opb_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [OPW-1:0]  out_q, out_d;
    logic            carry_q, carry_d;
    logic [IDW-1:0]  out_id_q, out_id_d;
    logic            valid_q, valid_d;

    logic [NREQ-1:0] pick_win;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    logic [OPW-1:0]  sum_lo;
    logic            sum_co;

    add_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req_i (bus.REQ),
        .ptr_i (ptr_q),
        .win_o (pick_win),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    ADD u_add (
        .A  (opa_q),
        .B  (opb_q),
        .S  (sum_lo),
        .CO (sum_co)
    );

    // State and datapath registers; reset overrides every transition.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            id_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            gnt_q    <= '0;
            out_q    <= '0;
            carry_q  <= 1'b0;
            out_id_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            gnt_q    <= gnt_d;
            out_q    <= out_d;
            carry_q  <= carry_d;
            out_id_q <= out_id_d;
            valid_q  <= valid_d;
        end
    end

    // Next-state: grant and capture in IDLE, add in EXEC, hold result until accepted in DONE.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        gnt_d    = '0;
        out_d    = out_q;
        carry_d  = carry_q;
        out_id_d = out_id_q;
        valid_d  = valid_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    opa_d   = bus.A_BUS[32'(pick_idx)*OPW +: OPW];
                    opb_d   = bus.B_BUS[32'(pick_idx)*OPW +: OPW];
                    id_d    = pick_idx;
                    gnt_d   = pick_win;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                out_d    = sum_lo;
                carry_d  = sum_co;
                out_id_d = id_q;
                valid_d  = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                if (bus.OUT_READY) begin
                    valid_d = 1'b0;
                    ptr_d   = IDW'((32'(id_q) + 1) % NREQ);
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.GNT       = gnt_q;
    assign bus.OUT       = out_q;
    assign bus.CARRY     = carry_q;
    assign bus.OUT_ID    = out_id_q;
    assign bus.OUT_VALID = valid_q;
    assign bus.BUSY      = (state_q != IDLE);

endmodule

// File: tb/tb_add_share_arbiter.sv
// Randomized self-checking bench for add_share_arbiter against a transaction-level model.
module tb_add_share_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;
    int unsigned m_ptr = 0;

    add_share_arbiter_if #(.NREQ(4), .IDW(2)) bus ();

    add_share_arbiter #(.NREQ(4), .IDW(2)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Winner = first requesting lane at ptr, ptr+1, ... modulo 4.
    function automatic int unsigned model_pick(input logic [3:0] req, input int unsigned ptr);
        for (int unsigned k = 0; k < 4; k++) begin
            if (req[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return 0;
    endfunction

    // mode: 0 keep REQ, 1 drop winner's REQ after GNT, 2 scramble all inputs after GNT
    task automatic run_txn(input logic [3:0] req, input logic [31:0] a, input logic [31:0] b,
                           input int unsigned hold, input int unsigned mode,
                           output logic [1:0] got_id, output logic [7:0] got_out,
                           output logic got_carry);
        int unsigned w;
        logic [7:0] ea, eb;
        logic [8:0] s;
        logic [3:0] onehot;
        bus.REQ       = req;
        bus.A_BUS     = a;
        bus.B_BUS     = b;
        bus.OUT_READY = (hold == 0);
        w      = model_pick(req, m_ptr);
        ea     = a[8*w +: 8];
        eb     = b[8*w +: 8];
        s      = 9'(ea) + 9'(eb);
        onehot = 4'b0001 << w;
        tick();
        check_eq("gnt_pulse", 32'(bus.GNT), 32'(onehot));
        check_eq("busy_exec", 32'(bus.BUSY), 1);
        check_eq("valid_exec", 32'(bus.OUT_VALID), 0);
        if (mode == 1) bus.REQ[w] = 1'b0;
        if (mode == 2) begin
            bus.REQ   = 4'($urandom);
            bus.A_BUS = $urandom;
            bus.B_BUS = $urandom;
        end
        tick();
        check_eq("gnt_clear", 32'(bus.GNT), 0);
        check_eq("valid_rise", 32'(bus.OUT_VALID), 1);
        check_eq("sum", 32'(bus.OUT), 32'(s[7:0]));
        check_eq("carry", 32'(bus.CARRY), 32'(s[8]));
        check_eq("out_id", 32'(bus.OUT_ID), w);
        got_id    = bus.OUT_ID;
        got_out   = bus.OUT;
        got_carry = bus.CARRY;
        for (int unsigned i = 0; i < hold; i++) begin
            tick();
            check_eq("hold_valid", 32'(bus.OUT_VALID), 1);
            check_eq("hold_sum", 32'(bus.OUT), 32'(s[7:0]));
            check_eq("hold_carry", 32'(bus.CARRY), 32'(s[8]));
            check_eq("hold_id", 32'(bus.OUT_ID), w);
            check_eq("hold_gnt", 32'(bus.GNT), 0);
            check_eq("hold_busy", 32'(bus.BUSY), 1);
        end
        bus.OUT_READY = 1'b1;
        tick();
        check_eq("accept_valid", 32'(bus.OUT_VALID), 0);
        check_eq("accept_busy", 32'(bus.BUSY), 0);
        check_eq("accept_sum_kept", 32'(bus.OUT), 32'(s[7:0]));
        check_eq("accept_id_kept", 32'(bus.OUT_ID), w);
        m_ptr = (w + 1) % 4;
    endtask

    task automatic idle_cycles(input int unsigned n);
        bus.REQ = '0;
        for (int unsigned i = 0; i < n; i++) begin
            tick();
            check_eq("idle_gnt", 32'(bus.GNT), 0);
            check_eq("idle_valid", 32'(bus.OUT_VALID), 0);
            check_eq("idle_busy", 32'(bus.BUSY), 0);
        end
    endtask

    initial begin
        logic [1:0] gid;
        logic [7:0] gout;
        logic       gc;
        int unsigned rr_order [5] = '{0, 1, 2, 3, 0};

        bus.REQ       = '0;
        bus.A_BUS     = '0;
        bus.B_BUS     = '0;
        bus.OUT_READY = 1'b0;
        tick();
        tick();
        check_eq("rst_gnt", 32'(bus.GNT), 0);
        check_eq("rst_out", 32'(bus.OUT), 0);
        check_eq("rst_carry", 32'(bus.CARRY), 0);
        check_eq("rst_id", 32'(bus.OUT_ID), 0);
        check_eq("rst_valid", 32'(bus.OUT_VALID), 0);
        check_eq("rst_busy", 32'(bus.BUSY), 0);
        rst = 1'b0;
        m_ptr = 0;

        // Round-robin with all lanes requesting continuously.
        for (int unsigned i = 0; i < 5; i++) begin
            run_txn(4'b1111, 32'h40302010 + i, 32'h04030201 + 32'(i << 8), 0, 0, gid, gout, gc);
            check_eq("rr_order", 32'(gid), rr_order[i]);
        end

        // Single requester on lane 1.
        idle_cycles(2);
        run_txn(4'b0010, 32'h00001200, 32'h00003400, 0, 1, gid, gout, gc);
        check_eq("single_sum", 32'(gout), 32'h46);
        check_eq("single_carry", 32'(gc), 0);
        check_eq("single_id", 32'(gid), 1);

        // Overflow on lane 0.
        run_txn(4'b0001, 32'h000000FF, 32'h00000001, 0, 1, gid, gout, gc);
        check_eq("ovf_ff_sum", 32'(gout), 0);
        check_eq("ovf_ff_carry", 32'(gc), 1);
        run_txn(4'b0001, 32'h00000080, 32'h00000080, 0, 1, gid, gout, gc);
        check_eq("ovf_80_sum", 32'(gout), 0);
        check_eq("ovf_80_carry", 32'(gc), 1);

        // Backpressure for 5 cycles.
        run_txn(4'b0100, 32'h00AB0000, 32'h00660000, 5, 1, gid, gout, gc);
        check_eq("bp_sum", 32'(gout), 32'h11);
        check_eq("bp_carry", 32'(gc), 1);

        // Reset during EXEC; pointer was 3 beforehand.
        bus.REQ       = 4'b0010;
        bus.A_BUS     = 32'h00007700;
        bus.B_BUS     = 32'h00001100;
        bus.OUT_READY = 1'b1;
        tick();
        check_eq("mid_gnt", 32'(bus.GNT), 32'b0010);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_ptr = 0;
        check_eq("mid_valid", 32'(bus.OUT_VALID), 0);
        check_eq("mid_out", 32'(bus.OUT), 0);
        check_eq("mid_carry", 32'(bus.CARRY), 0);
        check_eq("mid_id", 32'(bus.OUT_ID), 0);
        check_eq("mid_gnt_clr", 32'(bus.GNT), 0);
        check_eq("mid_busy", 32'(bus.BUSY), 0);
        idle_cycles(2);
        run_txn(4'b0110, 32'h00332211, 32'h00010101, 0, 1, gid, gout, gc);
        check_eq("post_rst_ptr", 32'(gid), 1);
        run_txn(4'b0100, 32'h00500000, 32'h00050000, 0, 1, gid, gout, gc);
        check_eq("post_rst_lane2", 32'(gout), 32'h55);

        // Single lane 3 request dropped after its grant: no second grant.
        run_txn(4'b1000, 32'h9A000000, 32'h01000000, 0, 1, gid, gout, gc);
        check_eq("nodup_id", 32'(gid), 3);
        idle_cycles(6);

        // Randomized transactions with gaps, backpressure and input scrambling.
        for (int unsigned t = 0; t < 60; t++) begin
            run_txn(4'($urandom_range(1, 15)), $urandom, $urandom,
                    $urandom_range(0, 3), $urandom_range(0, 2), gid, gout, gc);
            idle_cycles($urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/add_share_arbiter.md
Name: add_share_arbiter

Overview:
- Shares one 8-bit ADD adder unit between NREQ requesters.
- Each requester presents an A/B operand pair with a REQ line.
- The block picks a winner by round-robin and latches its operands, then feeds them through ADD.
- It registers the sum, carry and winner ID, and holds them under a valid/ready output handshake.
- Sits between requester blocks and downstream result consumers, at TOP level next to the existing registered-adder path.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester ID. Must equal clog2(NREQ).

Ports:
- CLK  input  1  system clock, rising edge.
- RESET  input  1  synchronous, active-high reset.
- REQ  input  NREQ  per-requester request. Held with operands until its GNT pulse is seen.
- A_BUS  input  8*NREQ  operand A. Requester i uses bits [8i+7:8i].
- B_BUS  input  8*NREQ  operand B, same packing as A_BUS.
- GNT  output  NREQ  one-hot, one-cycle grant pulse (registered).
- OUT  output  8  sum, modulo 256.
- CARRY  output  1  carry-out of the 8-bit add.
- OUT_ID  output  IDW  index of the requester that owns OUT.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  consumer accepts the result.
- BUSY  output  1  high whenever state is not IDLE.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: all state is updated only on posedge CLK, and RESET is sampled on that edge.
- Reset values:
  - state = IDLE
  - GNT = 0, OUT = 0, CARRY = 0, OUT_ID = 0, OUT_VALID = 0, BUSY = 0
  - round-robin pointer PTR = 0
  - operand latches = 0
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - If REQ == 0, stay in IDLE.
  - Otherwise the winner is the first i with REQ[i]=1, searching PTR, PTR+1, … with wrap mod NREQ.
  - On that edge: latch the winner's A and B into OPA/OPB, latch its index into ID, set GNT[winner]=1, go to EXEC.
- EXEC:
  - GNT returns to 0.
  - OPA/OPB drive the ADD instance.
  - On the edge: OUT <= low 8 bits, CARRY <= bit 8 of the 9-bit sum OPA+OPB, OUT_ID <= ID, OUT_VALID <= 1, go to DONE.
- DONE:
  - OUT, CARRY, OUT_ID and OUT_VALID hold stable.
  - On an edge where OUT_READY=1: OUT_VALID <= 0, PTR <= (ID+1) mod NREQ, go to IDLE. OUT/CARRY/OUT_ID keep their last values.
- Latency:
  - REQ sampled at edge 0 → GNT high in cycle 1 → OUT_VALID high from edge 2.
  - Minimum 3 cycles per transaction when OUT_READY is held high.
- Requester rule:
  - On seeing GNT, drop REQ (or present a new operand pair) by the next edge.
  - IDLE is re-entered no earlier than 2 edges after GNT, so a single request is never granted twice.
- OUT_READY while OUT_VALID=0 is ignored.
- REQ changes outside IDLE are ignored. Operands are captured only in IDLE.
- Fairness: a requester that holds REQ is granted within NREQ transactions.
- Sum wrap: 0xFF+0x01 → OUT=0x00, CARRY=1.
- RESET asserted in any state, including mid-EXEC or DONE: the transaction is discarded without OUT_VALID and all reset values are restored on that edge. RESET has priority over every transition.

Decomposition:
- Shared package holds:
  - state encoding constants IDLE=2'd0, EXEC=2'd1, DONE=2'd2
  - default NREQ
  - operand width constant 8
- One sub-module, add_rr_pick:
  - combinational round-robin picker
  - inputs: REQ, PTR
  - outputs: one-hot winner, winner index, any-request flag
- The ADD unit is instantiated unchanged.

Test Plan:
- Single requester: RESET released, REQ=4'b0010, lane1 A=0x12 B=0x34.
  Required: GNT=4'b0010 for exactly one cycle; OUT=0x46, CARRY=0, OUT_ID=1 with OUT_VALID rising 2 edges after REQ sampled; OUT_READY=1 clears it.
- Overflow: lane0 A=0xFF B=0x01.
  Required: OUT=0x00, CARRY=1. Lane0 A=0x80 B=0x80 gives OUT=0x00, CARRY=1.
- Round-robin: all four REQ held high continuously, OUT_READY=1.
  Required: grant order 0,1,2,3,0. OUT_ID sequence matches, and each lane's sum is correct for its distinct operands.
- Backpressure: OUT_READY=0 for 5 cycles after OUT_VALID.
  Required: OUT/CARRY/OUT_ID stable, no new GNT, BUSY=1. Releasing OUT_READY returns to IDLE next edge.
- Reset mid-operation: assert RESET in the EXEC cycle.
  Required: next edge OUT_VALID=0, OUT=0, GNT=0, PTR=0. The next request from lane2 (with lane0 idle) is granted normally.
- No duplicate grant: REQ[3] dropped on the edge after GNT[3].
  Required: exactly one OUT_VALID transaction for lane3 and no further GNT.
